mode_manager: RTL and testbench



---
 rtl/mode_manager.sv | 119 +++++++++++
 tb/tb_mode_manager.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mode_manager.sv
// Operating-mode controller: decodes the Arduino command byte into a one-hot mode
// enable, with a stability filter on mode/error commands and a latched emergency stop.
module mode_manager #(
  parameter int CMD_WIDTH      = 8,
  parameter int NUM_MODES      = 4,
  parameter int CONFIRM_CYCLES = 3,
  parameter int DEFAULT_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CMD_WIDTH-1:0]         arduino_command,
  output logic [NUM_MODES-1:0]         mode_onehot,
  output logic [$clog2(NUM_MODES)-1:0] mode_idx,
  output logic                         estop_active,
  output logic                         mode_changed,
  output logic                         cmd_error
);

  localparam int LW = CMD_WIDTH - 4;
  localparam int IW = $clog2(NUM_MODES);
  localparam int CW = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CW-1:0] CONF = CW'(CONFIRM_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [NUM_MODES-1:0] OH_ONE = NUM_MODES'(1);

  typedef enum logic [2:0] {C_NOP, C_ESTOP, C_MODE, C_CLEAR, C_ERR} cls_t;
  typedef enum logic [1:0] {S_INIT, S_RUN, S_ESTOP} state_t;

  state_t        state;
  cls_t          cur_cls, last_cls;
  logic [3:0]    cmd_h;
  logic [LW-1:0] cmd_l, last_l;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] cmd_idx;
  logic          same, fire;

  assign cmd_h   = arduino_command[CMD_WIDTH-1 -: 4];
  assign cmd_l   = arduino_command[LW-1:0];
  assign cmd_idx = IW'(cmd_l);

  always_comb begin
    cur_cls = C_ERR;
    if (arduino_command == '0)
      cur_cls = C_NOP;
    else if (arduino_command == '1)
      cur_cls = C_ESTOP;
    else if (cmd_h == 4'hA && {1'b0, cmd_l} < (LW+1)'(NUM_MODES))
      cur_cls = C_MODE;
    else if (cmd_h == 4'hC && cmd_l == '0)
      cur_cls = C_CLEAR;
  end

  // Fires on the edge the count arrives at CONFIRM_CYCLES; a fresh request that
  // reloads to 1 counts as arriving even when the old count was already saturated.
  always_comb begin
    same    = (cur_cls == last_cls) && (cmd_l == last_l);
    cnt_nxt = ONE;
    if (same)
      cnt_nxt = (cnt == CONF) ? cnt : cnt + ONE;
    fire = (cnt_nxt == CONF) && (!same || cnt != CONF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_INIT;
      cnt          <= '0;
      last_cls     <= C_NOP;
      last_l       <= '0;
      mode_onehot  <= '0;
      mode_idx     <= '0;
      estop_active <= 1'b0;
      mode_changed <= 1'b0;
      cmd_error    <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      cmd_error    <= 1'b0;
      case (state)
        S_INIT: begin
          state        <= S_RUN;
          cnt          <= '0;
          mode_idx     <= IW'(DEFAULT_MODE);
          mode_onehot  <= OH_ONE << IW'(DEFAULT_MODE);
          mode_changed <= 1'b1;
        end
        S_RUN: begin
          cnt      <= cnt_nxt;
          last_cls <= cur_cls;
          last_l   <= cmd_l;
          if (cur_cls == C_ESTOP) begin
            state        <= S_ESTOP;
            mode_onehot  <= '0;
            estop_active <= 1'b1;
          end else if (fire && cur_cls == C_MODE && cmd_idx != mode_idx) begin
            mode_idx     <= cmd_idx;
            mode_onehot  <= OH_ONE << cmd_idx;
            mode_changed <= 1'b1;
          end else if (fire && cur_cls == C_ERR) begin
            cmd_error <= 1'b1;
          end
        end
        S_ESTOP: begin
          cnt      <= cnt_nxt;
          last_cls <= cur_cls;
          last_l   <= cmd_l;
          // Leaving ESTOP always lands in Manual, whatever mode was active before.
          if (fire && cur_cls == C_CLEAR) begin
            state        <= S_RUN;
            mode_idx     <= '0;
            mode_onehot  <= OH_ONE;
            estop_active <= 1'b0;
            mode_changed <= 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mode_manager.sv
// Self-checking bench for mode_manager: default configuration plus a
// CONFIRM_CYCLES=1 / NUM_MODES=2 instance, checked cycle by cycle from a scoreboard.
module tb_mode_manager;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1, rst2 = 1'b1;
  logic [7:0] cmd1 = 8'h00, cmd2 = 8'h00;
  logic [3:0] oh1;
  logic [1:0] idx1;
  logic       es1, chg1, err1;
  logic [1:0] oh2;
  logic [0:0] idx2;
  logic       es2, chg2, err2;
  logic [8:0] obs1, obs2;

  mode_manager u_dut (
    .clk(clk), .rst(rst1), .arduino_command(cmd1),
    .mode_onehot(oh1), .mode_idx(idx1), .estop_active(es1),
    .mode_changed(chg1), .cmd_error(err1)
  );

  mode_manager #(.CMD_WIDTH(8), .NUM_MODES(2), .CONFIRM_CYCLES(1), .DEFAULT_MODE(0)) u_fast (
    .clk(clk), .rst(rst2), .arduino_command(cmd2),
    .mode_onehot(oh2), .mode_idx(idx2), .estop_active(es2),
    .mode_changed(chg2), .cmd_error(err2)
  );

  assign obs1 = {oh1, idx1, es1, chg1, err1};
  assign obs2 = {3'b000, oh2, idx2, es2, chg2, err2};

  typedef struct {
    logic       rst;
    logic [7:0] cmd;
    logic [8:0] exp;
  } stim_t;

  stim_t      stim_q[$];
  logic [8:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [8:0] e1(logic [3:0] oh, logic [1:0] idx, logic es, logic chg, logic err);
    return {oh, idx, es, chg, err};
  endfunction

  function automatic logic [8:0] e2(logic [1:0] oh, logic idx, logic es, logic chg, logic err);
    return {3'b000, oh, idx, es, chg, err};
  endfunction

  task automatic add(input logic r, input logic [7:0] c, input logic [8:0] e, input int n);
    repeat (n) stim_q.push_back('{rst: r, cmd: c, exp: e});
  endtask

  task automatic test_reset();
    stim_t s; logic [8:0] e;
    add(1, 8'h00, e1(4'b0000, 0, 0, 0, 0), 2);
    add(0, 8'h00, e1(4'b0001, 0, 0, 1, 0), 1);
    add(0, 8'h00, e1(4'b0001, 0, 0, 0, 0), 2);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); rst1 = s.rst; cmd1 = s.cmd; exp_q.push_back(s.exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin errors++; $display("FAIL reset step %0d: got %b expected %b", i, obs1, e); end
    end
  endtask

  task automatic test_confirm();
    stim_t s; logic [8:0] e;
    add(0, 8'hA1, e1(4'b0001, 0, 0, 0, 0), 2);
    add(0, 8'hA1, e1(4'b0010, 1, 0, 1, 0), 1);
    add(0, 8'hA1, e1(4'b0010, 1, 0, 0, 0), 10);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); rst1 = s.rst; cmd1 = s.cmd; exp_q.push_back(s.exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin errors++; $display("FAIL confirm step %0d: got %b expected %b", i, obs1, e); end
    end
  endtask

  task automatic test_glitch();
    stim_t s; logic [8:0] e;
    add(0, 8'hA2, e1(4'b0010, 1, 0, 0, 0), 2);
    add(0, 8'h00, e1(4'b0010, 1, 0, 0, 0), 2);
    add(0, 8'hA2, e1(4'b0010, 1, 0, 0, 0), 2);
    add(0, 8'hA3, e1(4'b0010, 1, 0, 0, 0), 2);
    add(0, 8'hA3, e1(4'b1000, 3, 0, 1, 0), 1);
    add(0, 8'h00, e1(4'b1000, 3, 0, 0, 0), 1);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); rst1 = s.rst; cmd1 = s.cmd; exp_q.push_back(s.exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin errors++; $display("FAIL glitch step %0d: got %b expected %b", i, obs1, e); end
    end
  endtask

  task automatic test_error();
    stim_t s; logic [8:0] e;
    add(0, 8'hA7, e1(4'b1000, 3, 0, 0, 0), 2);
    add(0, 8'hA7, e1(4'b1000, 3, 0, 0, 1), 1);
    add(0, 8'hA7, e1(4'b1000, 3, 0, 0, 0), 2);
    add(0, 8'h55, e1(4'b1000, 3, 0, 0, 0), 2);
    add(0, 8'h55, e1(4'b1000, 3, 0, 0, 1), 1);
    add(0, 8'hA0, e1(4'b1000, 3, 0, 0, 0), 2);
    add(0, 8'hA0, e1(4'b0001, 0, 0, 1, 0), 1);
    add(0, 8'h00, e1(4'b0001, 0, 0, 0, 0), 1);
    add(0, 8'hA0, e1(4'b0001, 0, 0, 0, 0), 4);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); rst1 = s.rst; cmd1 = s.cmd; exp_q.push_back(s.exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin errors++; $display("FAIL error step %0d: got %b expected %b", i, obs1, e); end
    end
  endtask

  task automatic test_estop();
    stim_t s; logic [8:0] e;
    add(0, 8'hA1, e1(4'b0001, 0, 0, 0, 0), 2);
    add(0, 8'hA1, e1(4'b0010, 1, 0, 1, 0), 1);
    add(0, 8'hFF, e1(4'b0000, 1, 1, 0, 0), 1);
    add(0, 8'hA2, e1(4'b0000, 1, 1, 0, 0), 5);
    add(0, 8'h33, e1(4'b0000, 1, 1, 0, 0), 3);
    add(0, 8'hFF, e1(4'b0000, 1, 1, 0, 0), 2);
    add(0, 8'hC0, e1(4'b0000, 1, 1, 0, 0), 2);
    add(0, 8'hC0, e1(4'b0001, 0, 0, 1, 0), 1);
    add(0, 8'hC0, e1(4'b0001, 0, 0, 0, 0), 2);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); rst1 = s.rst; cmd1 = s.cmd; exp_q.push_back(s.exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin errors++; $display("FAIL estop step %0d: got %b expected %b", i, obs1, e); end
    end
  endtask

  task automatic test_reset_priority();
    stim_t s; logic [8:0] e;
    // ESTOP beats an in-progress confirmation; reset beats ESTOP
    add(0, 8'hA2, e1(4'b0001, 0, 0, 0, 0), 2);
    add(0, 8'hFF, e1(4'b0000, 0, 1, 0, 0), 1);
    add(1, 8'hFF, e1(4'b0000, 0, 0, 0, 0), 2);
    add(0, 8'h00, e1(4'b0001, 0, 0, 1, 0), 1);
    add(0, 8'hA2, e1(4'b0001, 0, 0, 0, 0), 2);
    add(1, 8'hA2, e1(4'b0000, 0, 0, 0, 0), 1);
    add(0, 8'hA2, e1(4'b0001, 0, 0, 1, 0), 1);
    add(0, 8'hA2, e1(4'b0001, 0, 0, 0, 0), 2);
    add(0, 8'hA2, e1(4'b0100, 2, 0, 1, 0), 1);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); rst1 = s.rst; cmd1 = s.cmd; exp_q.push_back(s.exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin errors++; $display("FAIL rst_prio step %0d: got %b expected %b", i, obs1, e); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s; logic [8:0] e;
    add(1, 8'h00, e2(2'b00, 0, 0, 0, 0), 2);
    add(0, 8'h00, e2(2'b01, 0, 0, 1, 0), 1);
    for (int k = 0; k < 4; k++) begin
      add(0, 8'hA1, e2(2'b10, 1, 0, 1, 0), 1);
      add(0, 8'hA0, e2(2'b01, 0, 0, 1, 0), 1);
    end
    add(0, 8'hA1, e2(2'b10, 1, 0, 1, 0), 1);
    add(0, 8'hA1, e2(2'b10, 1, 0, 0, 0), 1);
    add(0, 8'hA2, e2(2'b10, 1, 0, 0, 1), 1);
    add(0, 8'hA2, e2(2'b10, 1, 0, 0, 0), 1);
    add(0, 8'hA0, e2(2'b01, 0, 0, 1, 0), 1);
    add(1, 8'hA1, e2(2'b00, 0, 0, 0, 0), 2);
    add(0, 8'hA1, e2(2'b01, 0, 0, 1, 0), 1);
    add(0, 8'hA1, e2(2'b10, 1, 0, 1, 0), 1);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); rst2 = s.rst; cmd2 = s.cmd; exp_q.push_back(s.exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs2 !== e) begin errors++; $display("FAIL fast step %0d: got %b expected %b", i, obs2, e); end
    end
  endtask

  initial begin
    test_reset();
    test_confirm();
    test_glitch();
    test_error();
    test_estop();
    test_reset_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
